// File: rtl/mem_stage.sv
// mem_stage: load/store stage with req/ack memory handshake, bounded wait, stall and registered MEM/WB outputs
module mem_stage #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int TIMEOUT          = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_en_in,
  input  logic                        rd_mem_en_in,
  input  logic                        wr_mem_en_in,
  input  logic                        pc_en_in,
  input  logic [ARQ-1:0]              sr1_in,
  input  logic [ARQ-1:0]              srdest_in,
  input  logic [ARQ-1:0]              alu_result_in,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  output logic [ARQ-1:0]              mem_wdata,
  input  logic [ARQ-1:0]              mem_rdata,
  input  logic                        mem_ack,
  output logic                        stall,
  output logic                        wb_en_out,
  output logic                        pc_en_out,
  output logic [ARQ-1:0]              dest_out,
  output logic [ARQ-1:0]              result_out,
  output logic                        mem_err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_op, w_to;
  assign w_op = rd_mem_en_in | wr_mem_en_in;
  assign w_to = (r_state == WAIT) & ~mem_ack & (r_cnt == CW'(TIMEOUT - 1));
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: enter WAIT on a memory op, leave on ack or timeout
  always_comb begin
    w_next = (r_state == IDLE) ? (w_op ? WAIT : IDLE) : ((mem_ack | w_to) ? IDLE : WAIT);
  end
  // stall upstream while an access is being requested or awaited
  always_comb begin
    stall = (r_state == IDLE) ? w_op : (~mem_ack & ~w_to);
  end
  // memory interface, wait counter, error flag and MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_err    <= 1'b0;
      r_cnt      <= '0;
      wb_en_out  <= 1'b0;
      pc_en_out  <= 1'b0;
      dest_out   <= '0;
      result_out <= '0;
    end else if (r_state == IDLE) begin
      if (w_op) begin
        mem_req   <= 1'b1;
        mem_we    <= ~rd_mem_en_in;
        mem_addr  <= alu_result_in[MEMORY_ADDR_SIZE-1:0];
        mem_wdata <= sr1_in;
        r_cnt     <= '0;
        wb_en_out <= 1'b0;
        pc_en_out <= 1'b0;
      end else begin
        wb_en_out  <= wb_en_in;
        pc_en_out  <= pc_en_in;
        dest_out   <= srdest_in;
        result_out <= alu_result_in;
      end
    end else if (mem_ack) begin
      mem_req    <= 1'b0;
      dest_out   <= srdest_in;
      pc_en_out  <= pc_en_in;
      wb_en_out  <= ~mem_we & wb_en_in;
      result_out <= mem_we ? {{(ARQ-MEMORY_ADDR_SIZE){1'b0}}, mem_addr} : mem_rdata;
    end else if (w_to) begin
      mem_req   <= 1'b0;
      mem_err   <= 1'b1;
      wb_en_out <= 1'b0;
      pc_en_out <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level model
module tb_mem_stage;
  localparam int ARQ = 16;
  localparam int AW  = 13;
  localparam int TO  = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_en_in = 0, rd_mem_en_in = 0, wr_mem_en_in = 0, pc_en_in = 0;
  logic [ARQ-1:0] sr1_in = 0, srdest_in = 0, alu_result_in = 0, mem_rdata = 0;
  logic mem_ack = 0;
  logic mem_req, mem_we, stall, wb_en_out, pc_en_out, mem_err;
  logic [AW-1:0] mem_addr;
  logic [ARQ-1:0] mem_wdata, dest_out, result_out;
  int total = 0;
  int bad = 0;

  mem_stage #(.ARQ(ARQ), .MEMORY_ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .rd_mem_en_in(rd_mem_en_in),
    .wr_mem_en_in(wr_mem_en_in), .pc_en_in(pc_en_in), .sr1_in(sr1_in),
    .srdest_in(srdest_in), .alu_result_in(alu_result_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .wb_en_out(wb_en_out), .pc_en_out(pc_en_out), .dest_out(dest_out),
    .result_out(result_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one outstanding access recorded with its start cycle.
  typedef struct {
    bit            load;
    logic [AW-1:0] addr;
    int            start;
  } acc_t;
  acc_t acc;
  int cyc = 0;
  bit busy = 0, armed = 0, adv = 0;
  logic e_req = 0, e_we = 0, e_err = 0, e_wb = 0, e_pc = 0, e_dr_ok = 0;
  logic [AW-1:0] e_addr = 0;
  logic [ARQ-1:0] e_wdata = 0, e_dest = 0, e_res = 0;

  function automatic logic m_stall();
    return busy ? !(mem_ack || (cyc - acc.start) == TO) : (rd_mem_en_in || wr_mem_en_in);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    adv <= !m_stall();
    if (rst) begin
      busy <= 0; armed <= 1; e_req <= 0; e_we <= 0; e_err <= 0; e_wb <= 0; e_pc <= 0;
      e_addr <= 0; e_wdata <= 0; e_dest <= 0; e_res <= 0; e_dr_ok <= 1;
    end else if (!busy) begin
      if (rd_mem_en_in || wr_mem_en_in) begin
        busy <= 1;
        acc.load <= rd_mem_en_in;
        acc.addr <= alu_result_in[AW-1:0];
        acc.start <= cyc;
        e_req <= 1; e_we <= !rd_mem_en_in; e_addr <= alu_result_in[AW-1:0];
        e_wdata <= sr1_in; e_wb <= 0; e_pc <= 0; e_dr_ok <= 0;
      end else begin
        e_wb <= wb_en_in; e_pc <= pc_en_in; e_dest <= srdest_in; e_res <= alu_result_in; e_dr_ok <= 1;
      end
    end else if (mem_ack) begin
      busy <= 0; e_req <= 0; e_dest <= srdest_in; e_pc <= pc_en_in; e_dr_ok <= 1;
      e_res <= acc.load ? mem_rdata : {{(ARQ-AW){1'b0}}, acc.addr};
      e_wb <= acc.load ? wb_en_in : 1'b0;
    end else if ((cyc - acc.start) == TO) begin
      busy <= 0; e_req <= 0; e_err <= 1; e_wb <= 0; e_pc <= 0; e_dr_ok <= 0;
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("stall", stall, m_stall());
      chk("mem_req", mem_req, e_req);
      chk("mem_err", mem_err, e_err);
      chk("wb_en_out", wb_en_out, e_wb);
      chk("pc_en_out", pc_en_out, e_pc);
      if (e_req) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_dr_ok) begin
        chk("dest_out", dest_out, e_dest);
        chk("result_out", result_out, e_res);
      end
    end
  end

  initial begin
    int n, wcnt, dly;
    logic prev_req;
    tick(); tick();
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_err", mem_err, 0);
    chk("rst wb_en_out", wb_en_out, 0);
    chk("rst result_out", result_out, 0);
    chk("rst stall", stall, 0);
    rst = 0;
    // pass-through
    wb_en_in = 1; srdest_in = 3; alu_result_in = 16'h00A5;
    #1 chk("t1 stall", stall, 0);
    tick();
    chk("t1 wb", wb_en_out, 1); chk("t1 dest", dest_out, 3); chk("t1 res", result_out, 16'h00A5);
    // load, ack in 2nd WAIT cycle
    rd_mem_en_in = 1; alu_result_in = 16'h1234; srdest_in = 5; wb_en_in = 1;
    #1 chk("t2 stall req", stall, 1);
    tick();
    chk("t2 req", mem_req, 1); chk("t2 addr", mem_addr, 13'h1234); chk("t2 we", mem_we, 0);
    chk("t2 stall w1", stall, 1);
    tick();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    #1 chk("t2 stall ack", stall, 0);
    tick();
    mem_ack = 0; rd_mem_en_in = 0; wb_en_in = 0;
    chk("t2 res", result_out, 16'hBEEF); chk("t2 wb", wb_en_out, 1); chk("t2 dest", dest_out, 5);
    chk("t2 req drop", mem_req, 0);
    // store, immediate ack
    wr_mem_en_in = 1; sr1_in = 16'h00FF; alu_result_in = 16'h0010; srdest_in = 7; wb_en_in = 1;
    #1 chk("t3 stall", stall, 1);
    tick();
    chk("t3 we", mem_we, 1); chk("t3 wdata", mem_wdata, 16'h00FF); chk("t3 addr", mem_addr, 13'h0010);
    mem_ack = 1;
    #1 chk("t3 stall ack", stall, 0);
    tick();
    mem_ack = 0; wr_mem_en_in = 0; wb_en_in = 0;
    chk("t3 wb", wb_en_out, 0); chk("t3 res", result_out, 16'h0010);
    // timeout
    rd_mem_en_in = 1; alu_result_in = 16'h0042;
    tick();
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      if (!stall) rd_mem_en_in = 0;
      tick();
    end
    chk("t4 req cycles", n, TO); chk("t4 err", mem_err, 1); chk("t4 wb", wb_en_out, 0);
    rd_mem_en_in = 0; wb_en_in = 1; srdest_in = 9; alu_result_in = 16'h0077;
    tick();
    chk("t4 pass wb", wb_en_out, 1); chk("t4 pass res", result_out, 16'h0077); chk("t4 err sticky", mem_err, 1);
    // reset in 3rd WAIT cycle, then stray ack
    wb_en_in = 0; rd_mem_en_in = 1; alu_result_in = 16'h0555; srdest_in = 2;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0; rd_mem_en_in = 0; alu_result_in = 0; srdest_in = 0; pc_en_in = 0; sr1_in = 0; mem_ack = 1;
    chk("t5 req", mem_req, 0); chk("t5 err", mem_err, 0); chk("t5 wb", wb_en_out, 0);
    chk("t5 res", result_out, 0); chk("t5 dest", dest_out, 0); chk("t5 addr", mem_addr, 0);
    tick();
    mem_ack = 0;
    chk("t5 stray req", mem_req, 0); chk("t5 stray res", result_out, 0); chk("t5 stray wb", wb_en_out, 0);
    // rd and wr together, then back-to-back load
    rd_mem_en_in = 1; wr_mem_en_in = 1; alu_result_in = 16'h0ABC; srdest_in = 4; wb_en_in = 1;
    tick();
    chk("t6 we", mem_we, 0);
    mem_ack = 1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 0; wr_mem_en_in = 0; alu_result_in = 16'h0333;
    chk("t6 res", result_out, 16'h1111); chk("t6 req drop", mem_req, 0);
    #1 chk("t6 stall b2b", stall, 1);
    tick();
    chk("t6 req again", mem_req, 1); chk("t6 addr", mem_addr, 13'h0333);
    mem_ack = 1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 0; rd_mem_en_in = 0; wb_en_in = 0;
    // randomized traffic with a responding memory of random latency
    prev_req = 0; wcnt = 0; dly = 0;
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      if (mem_req && !prev_req) begin
        wcnt = 0;
        dly = $urandom_range(0, 17);
      end
      if (mem_req) begin
        mem_ack = (wcnt == dly);
        wcnt++;
      end else mem_ack = ($urandom_range(0, 15) == 0);
      mem_rdata = 16'($urandom);
      prev_req = mem_req;
      if (adv) begin
        rd_mem_en_in = ($urandom_range(0, 2) == 0);
        wr_mem_en_in = ($urandom_range(0, 2) == 0);
        wb_en_in = ($urandom_range(0, 1) == 1);
        pc_en_in = ($urandom_range(0, 1) == 1);
        sr1_in = 16'($urandom);
        srdest_in = 16'($urandom);
        alu_result_in = 16'($urandom);
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit pipeline. Sits directly downstream of the EXE/MEM pipeline register and consumes its outputs: write-back enable, memory read/write enables, PC enable, store data, destination register and ALU result.
- Performs loads and stores over a req/ack handshake to the data memory, with a bounded wait.
- Stalls the upstream pipeline while an access is outstanding.
- Drives a registered MEM/WB interface to the write-back stage.

Parameters:
- ARQ, 16, datapath width.
- MEMORY_ADDR_SIZE, 13, data-memory address width.
- TIMEOUT, 15, maximum wait cycles for mem_ack before the access is aborted (must be >= 1).

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- wb_en_in, in, 1, write-back enable from EXE/MEM.
- rd_mem_en_in, in, 1, load request.
- wr_mem_en_in, in, 1, store request.
- pc_en_in, in, 1, PC enable, passed through.
- sr1_in, in, ARQ, store data.
- srdest_in, in, ARQ, destination register identifier.
- alu_result_in, in, ARQ, ALU result; low MEMORY_ADDR_SIZE bits are the memory address.
- mem_req, out, 1, memory request, registered.
- mem_we, out, 1, 1 = write, 0 = read; valid while mem_req=1.
- mem_addr, out, MEMORY_ADDR_SIZE, access address.
- mem_wdata, out, ARQ, store data.
- mem_rdata, in, ARQ, load data; valid when mem_ack=1.
- mem_ack, in, 1, access complete, single-cycle pulse.
- stall, out, 1, combinational; upstream holds all *_in stable while 1.
- wb_en_out, out, 1, MEM/WB write-back enable.
- pc_en_out, out, 1, MEM/WB PC enable.
- dest_out, out, ARQ, MEM/WB destination register.
- result_out, out, ARQ, MEM/WB result.
- mem_err, out, 1, sticky timeout flag.

Behaviour:

Reset:
- rst=1 at an edge forces state IDLE and wait counter 0.
- All outputs go to 0, including mem_req, mem_we, mem_addr, mem_wdata, mem_err and the MEM/WB outputs.
- Reset mid-access abandons the access: mem_req is 0 after that edge, and a late mem_ack is ignored.

State IDLE:
- No memory op (rd=wr=0):
  - stall=0.
  - Next edge: wb_en_out<=wb_en_in, pc_en_out<=pc_en_in, dest_out<=srdest_in, result_out<=alu_result_in.
  - Latency 1 cycle.
- Memory op (rd or wr):
  - stall=1 (combinational).
  - Next edge latches mem_addr<=alu_result_in[MEMORY_ADDR_SIZE-1:0], mem_wdata<=sr1_in, mem_we<=~rd_mem_en_in.
  - Same edge sets mem_req<=1 and counter<=0, goes to WAIT, and loads a bubble into MEM/WB (wb_en_out=0, pc_en_out=0).
- rd and wr both 1: treated as a load; wr ignored.
- mem_ack in IDLE: ignored.

State WAIT:
- mem_req, mem_we, mem_addr, mem_wdata held stable.
- stall = ~mem_ack, unless the timeout fires.
- mem_ack=1:
  - stall=0, so upstream advances at this edge.
  - Next edge: mem_req<=0, state IDLE, dest_out<=srdest_in, pc_en_out<=pc_en_in.
  - Load: result_out<=mem_rdata, wb_en_out<=wb_en_in.
  - Store: result_out<=zero-extended mem_addr, wb_en_out<=0.
- mem_ack=0 and counter==TIMEOUT-1 (timeout):
  - stall=0 this cycle.
  - Next edge: mem_req<=0, mem_err<=1, bubble into MEM/WB, state IDLE.
- Otherwise: counter increments.

Latency and limits:
- Minimum load/store latency is 2 cycles (request cycle plus ack in the first WAIT cycle).
- The stage handles at most one outstanding access.
- Back-to-back memory ops each take their own IDLE request cycle.
- mem_err stays set until rst.
- Counter width is $clog2(TIMEOUT)+1; it never wraps.

Test Plan:
1. Pass-through: wb_en_in=1, rd=wr=0, srdest_in=3, alu_result_in=16'h00A5 -> next cycle wb_en_out=1, dest_out=3, result_out=16'h00A5; stall never asserted.
2. Load with one-cycle wait:
   - Stimulus: rd=1, alu_result_in=16'h1234, srdest_in=5; ack arrives in the 2nd WAIT cycle with mem_rdata=16'hBEEF.
   - Required: mem_addr=13'h1234 and mem_we=0; stall high for 2 cycles, low on the ack cycle; then result_out=16'hBEEF, wb_en_out=1, dest_out=5.
3. Store with immediate ack: wr=1, sr1_in=16'h00FF, alu_result_in=16'h0010, ack in the 1st WAIT cycle -> mem_we=1, mem_wdata=16'h00FF, mem_addr=13'h0010; wb_en_out=0; total stall 1 cycle.
4. Timeout: rd=1, mem_ack never asserted -> mem_req high exactly TIMEOUT (15) cycles, then drops; mem_err=1 and stays 1; MEM/WB bubble (wb_en_out=0); a later pass-through instruction proceeds normally.
5. Reset mid-access: rst pulsed in the 3rd WAIT cycle -> mem_req=0, all outputs 0 next cycle; a mem_ack pulse in the following cycle causes no output change.
6. Both enables plus back-to-back: rd=wr=1 -> mem_we=0 (treated as load); a second load presented immediately after the first completes -> new request cycle with stall=1, mem_req reasserted one cycle after the first drops.
